// File: rtl/digit_serial_addsub_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | addsub_pkg : shared types for the digit-serial adder/subtractor          |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/digit_serial_addsub_rca_digit.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | rca_digit : DIGIT-wide combinational ripple-carry adder slice            |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module rca_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             c_in,
  output logic [DIGIT-1:0] s,
  output logic             c_out,
  output logic             c_msb
);

  logic [DIGIT:0] w_c;

  assign w_c[0] = c_in;

  for (genvar i = 0; i < DIGIT; i++) begin : g_bit
    assign s[i]     = a[i] ^ b[i] ^ w_c[i];
    assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
  end

  assign c_out = w_c[DIGIT];
  // Carry into the top bit, needed for signed-overflow detection.
  assign c_msb = w_c[DIGIT-1];

endmodule
`default_nettype wire

// File: rtl/digit_serial_addsub.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | digit_serial_addsub : DIGIT bits/cycle add/subtract with valid/ready    |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module digit_serial_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             ovf
);

  localparam int NDIG  = WIDTH / DIGIT;
  localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, s_q, s_d;
  logic               carry_q, carry_d, c_out_q, c_out_d, ovf_q, ovf_d;

  logic [DIGIT-1:0]   w_sum;
  logic               w_cout, w_cmsb, w_last;
  logic [WIDTH-1:0]   w_s_shift;

  rca_digit #(.DIGIT(DIGIT)) u_rca (
    .a     (a_q[DIGIT-1:0]),
    .b     (b_q[DIGIT-1:0]),
    .c_in  (carry_q),
    .s     (w_sum),
    .c_out (w_cout),
    .c_msb (w_cmsb)
  );

  // New digit enters at the MSB; after NDIG cycles the result is in order.
  if (NDIG == 1) begin : g_single
    assign w_s_shift = w_sum;
  end else begin : g_multi
    assign w_s_shift = {w_sum, s_q[WIDTH-1:DIGIT]};
  end

  assign w_last = (cnt_q == CNT_W'(NDIG - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = BUSY;
      BUSY:    if (w_last)    state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    c_out_d = c_out_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: if (in_valid) begin
        // Subtraction as a + ~b + 1, with borrow-in folded into the carry.
        a_d     = a;
        b_d     = b ^ {WIDTH{sub}};
        carry_d = c_in ^ sub;
        cnt_d   = '0;
        s_d     = '0;
        c_out_d = 1'b0;
        ovf_d   = 1'b0;
      end
      BUSY: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        s_d     = w_s_shift;
        carry_d = w_cout;
        cnt_d   = cnt_q + 1'b1;
        if (w_last) begin
          c_out_d = w_cout;
          ovf_d   = w_cmsb ^ w_cout;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
    end
  end

  assign s     = s_q;
  assign c_out = c_out_q;
  assign ovf   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_digit_serial_addsub.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_digit_serial_addsub : directed + reference-model checks, 3 configs   |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module tb_digit_serial_addsub;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cmp = 0;
  int err = 0;

  // 16/4 instance
  logic        iv16 = 0, ir16, ci16 = 0, sub16 = 0, ov16, or16 = 0, co16, ovf16;
  logic [15:0] a16 = 0, b16 = 0, s16;
  // 8/8 instance
  logic        iv8 = 0, ir8, ci8 = 0, sub8 = 0, ov8, or8 = 0, co8, ovf8;
  logic [7:0]  a8 = 0, b8 = 0, s8;
  // 32/4 instance
  logic        iv32 = 0, ir32, ci32 = 0, sub32 = 0, ov32, or32 = 0, co32, ovf32;
  logic [31:0] a32 = 0, b32 = 0, s32;

  digit_serial_addsub #(.WIDTH(16), .DIGIT(4)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
    .c_in(ci16), .sub(sub16), .out_valid(ov16), .out_ready(or16), .s(s16),
    .c_out(co16), .ovf(ovf16));

  digit_serial_addsub #(.WIDTH(8), .DIGIT(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .c_in(ci8), .sub(sub8), .out_valid(ov8), .out_ready(or8), .s(s8),
    .c_out(co8), .ovf(ovf8));

  digit_serial_addsub #(.WIDTH(32), .DIGIT(4)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32),
    .c_in(ci32), .sub(sub32), .out_valid(ov32), .out_ready(or32), .s(s32),
    .c_out(co32), .ovf(ovf32));

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  // Arithmetic reference: exact integer result, then range tests.
  function automatic void ref_model(input int w, input longint ua, input longint ub,
                                    input logic ci, input logic sb,
                                    output longint es, output logic ec, output logic ev);
    longint m, r, sa, sbv, sr, c;
    m   = longint'(1) << w;
    c   = ci ? 1 : 0;
    sa  = (ua >= m / 2) ? ua - m : ua;
    sbv = (ub >= m / 2) ? ub - m : ub;
    r   = sb ? ua - ub - c : ua + ub + c;
    sr  = sb ? sa - sbv - c : sa + sbv + c;
    es  = r & (m - 1);
    ec  = sb ? (r >= 0) : (r >= m);
    ev  = (sr >= m / 2) || (sr < -(m / 2));
  endfunction

  // Present operands for one accepting edge, then count edges until out_valid.
  task automatic run16(input logic [15:0] ta, input logic [15:0] tb_, input logic tc,
                       input logic ts, output int lat);
    a16 = ta; b16 = tb_; ci16 = tc; sub16 = ts; iv16 = 1'b1;
    @(posedge clk); #1;
    iv16 = 1'b0;
    lat = 0;
    while (!ov16 && lat < 40) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic release16();
    or16 = 1'b1;
    @(posedge clk); #1;
    or16 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cmp++; if (ir16 !== 1'b1) begin err++; $display("FAIL reset_in_ready: got %b expected 1", ir16); end
    cmp++; if (ov16 !== 1'b0) begin err++; $display("FAIL reset_out_valid: got %b expected 0", ov16); end
    cmp++; if ({s16, co16, ovf16} !== 18'h0) begin err++; $display("FAIL reset_outputs: got s=%h c=%b v=%b expected 0", s16, co16, ovf16); end
  endtask

  task automatic test_add();
    logic [15:0] va[3] = '{16'hFFFF, 16'h7FFF, 16'h1234};
    logic [15:0] vb[3] = '{16'h0001, 16'h0001, 16'h4321};
    logic        vc[3] = '{1'b0, 1'b0, 1'b1};
    logic [15:0] es[3] = '{16'h0000, 16'h8000, 16'h5556};
    logic        ec[3] = '{1'b1, 1'b0, 1'b0};
    logic        ev[3] = '{1'b0, 1'b1, 1'b0};
    int lat;
    for (int i = 0; i < 3; i++) begin
      run16(va[i], vb[i], vc[i], 1'b0, lat);
      cmp++; if (lat !== 4) begin err++; $display("FAIL add_latency[%0d]: got %0d expected 4", i, lat); end
      cmp++; if (s16 !== es[i]) begin err++; $display("FAIL add_s[%0d]: got %h expected %h", i, s16, es[i]); end
      cmp++; if (co16 !== ec[i]) begin err++; $display("FAIL add_c_out[%0d]: got %b expected %b", i, co16, ec[i]); end
      cmp++; if (ovf16 !== ev[i]) begin err++; $display("FAIL add_ovf[%0d]: got %b expected %b", i, ovf16, ev[i]); end
      release16();
    end
  endtask

  task automatic test_sub();
    logic [15:0] va[3] = '{16'h8000, 16'h0003, 16'h0010};
    logic [15:0] vb[3] = '{16'h0001, 16'h0005, 16'h0001};
    logic        vc[3] = '{1'b0, 1'b0, 1'b1};
    logic [15:0] es[3] = '{16'h7FFF, 16'hFFFE, 16'h000E};
    logic        ec[3] = '{1'b1, 1'b0, 1'b1};
    logic        ev[3] = '{1'b1, 1'b0, 1'b0};
    int lat;
    for (int i = 0; i < 3; i++) begin
      run16(va[i], vb[i], vc[i], 1'b1, lat);
      cmp++; if (lat !== 4) begin err++; $display("FAIL sub_latency[%0d]: got %0d expected 4", i, lat); end
      cmp++; if (s16 !== es[i]) begin err++; $display("FAIL sub_s[%0d]: got %h expected %h", i, s16, es[i]); end
      cmp++; if (co16 !== ec[i]) begin err++; $display("FAIL sub_c_out[%0d]: got %b expected %b", i, co16, ec[i]); end
      cmp++; if (ovf16 !== ev[i]) begin err++; $display("FAIL sub_ovf[%0d]: got %b expected %b", i, ovf16, ev[i]); end
      release16();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    run16(16'h00F0, 16'h0F0F, 1'b0, 1'b0, lat);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      cmp++; if ({ov16, ir16} !== 2'b10) begin err++; $display("FAIL bp_handshake[%0d]: got valid=%b ready=%b expected 1/0", i, ov16, ir16); end
      cmp++; if ({s16, co16, ovf16} !== {16'h0FFF, 1'b0, 1'b0}) begin err++; $display("FAIL bp_hold[%0d]: got s=%h c=%b v=%b expected 0fff/0/0", i, s16, co16, ovf16); end
    end
    release16();
    cmp++; if ({ov16, ir16} !== 2'b01) begin err++; $display("FAIL bp_release: got valid=%b ready=%b expected 0/1", ov16, ir16); end
  endtask

  task automatic test_busy_ignore();
    int lat;
    a16 = 16'h0100; b16 = 16'h0023; ci16 = 1'b0; sub16 = 1'b0; iv16 = 1'b1;
    @(posedge clk); #1;
    lat = 0;
    while (!ov16 && lat < 40) begin
      a16 = 16'($urandom); b16 = 16'($urandom); sub16 = 1'b1; ci16 = 1'b1;
      cmp++; if (ir16 !== 1'b0) begin err++; $display("FAIL busy_in_ready[%0d]: got %b expected 0", lat, ir16); end
      @(posedge clk); #1; lat++;
    end
    cmp++; if (lat !== 4) begin err++; $display("FAIL busy_latency: got %0d expected 4", lat); end
    @(posedge clk); #1;
    cmp++; if ({ov16, s16, co16, ovf16} !== {1'b1, 16'h0123, 1'b0, 1'b0}) begin err++; $display("FAIL busy_result: got v=%b s=%h c=%b o=%b expected 1/0123/0/0", ov16, s16, co16, ovf16); end
    or16 = 1'b1;
    @(posedge clk); #1;
    or16 = 1'b0; iv16 = 1'b0;
    cmp++; if ({ir16, ov16} !== 2'b10) begin err++; $display("FAIL busy_return_idle: got ready=%b valid=%b expected 1/0", ir16, ov16); end
    @(posedge clk); #1;
    cmp++; if ({ir16, ov16} !== 2'b10) begin err++; $display("FAIL busy_no_second_accept: got ready=%b valid=%b expected 1/0", ir16, ov16); end
  endtask

  task automatic test_reset_mid_busy();
    int lat;
    a16 = 16'h1111; b16 = 16'h2222; ci16 = 1'b0; sub16 = 1'b0; iv16 = 1'b1;
    @(posedge clk); #1;
    iv16 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    cmp++; if ({ir16, ov16} !== 2'b10) begin err++; $display("FAIL rstbusy_state: got ready=%b valid=%b expected 1/0", ir16, ov16); end
    cmp++; if ({s16, co16, ovf16} !== 18'h0) begin err++; $display("FAIL rstbusy_outputs: got s=%h c=%b v=%b expected 0", s16, co16, ovf16); end
    repeat (6) @(posedge clk);
    #1;
    cmp++; if (ov16 !== 1'b0) begin err++; $display("FAIL rstbusy_no_result: got %b expected 0", ov16); end
    run16(16'h00FF, 16'h0001, 1'b0, 1'b0, lat);
    cmp++; if ({lat[3:0], s16, co16, ovf16} !== {4'd4, 16'h0100, 1'b0, 1'b0}) begin err++; $display("FAIL rstbusy_next_op: got lat=%0d s=%h c=%b v=%b expected 4/0100/0/0", lat, s16, co16, ovf16); end
    release16();
  endtask

  task automatic test_rand_w8();
    longint es; logic ec, ev; int lat;
    for (int n = 0; n < 12; n++) begin
      a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'($urandom); sub8 = 1'($urandom);
      ref_model(8, longint'({56'd0, a8}), longint'({56'd0, b8}), ci8, sub8, es, ec, ev);
      iv8 = 1'b1;
      @(posedge clk); #1;
      iv8 = 1'b0; lat = 0;
      while (!ov8 && lat < 40) begin @(posedge clk); #1; lat++; end
      cmp++; if (lat !== 1) begin err++; $display("FAIL w8_latency[%0d]: got %0d expected 1", n, lat); end
      cmp++; if ({s8, co8, ovf8} !== {es[7:0], ec, ev}) begin err++; $display("FAIL w8_result[%0d]: got s=%h c=%b v=%b expected %h/%b/%b", n, s8, co8, ovf8, es[7:0], ec, ev); end
      or8 = 1'b1; @(posedge clk); #1; or8 = 1'b0;
    end
  endtask

  task automatic test_rand_w32();
    longint es; logic ec, ev; int lat;
    for (int n = 0; n < 12; n++) begin
      a32 = $urandom; b32 = $urandom; ci32 = 1'($urandom); sub32 = 1'($urandom);
      if (n == 0) begin a32 = 32'h7FFF_FFFF; b32 = 32'h0000_0001; ci32 = 1'b0; sub32 = 1'b0; end
      ref_model(32, longint'({32'd0, a32}), longint'({32'd0, b32}), ci32, sub32, es, ec, ev);
      iv32 = 1'b1;
      @(posedge clk); #1;
      iv32 = 1'b0; lat = 0;
      while (!ov32 && lat < 40) begin @(posedge clk); #1; lat++; end
      cmp++; if (lat !== 8) begin err++; $display("FAIL w32_latency[%0d]: got %0d expected 8", n, lat); end
      cmp++; if ({s32, co32, ovf32} !== {es[31:0], ec, ev}) begin err++; $display("FAIL w32_result[%0d]: got s=%h c=%b v=%b expected %h/%b/%b", n, s32, co32, ovf32, es[31:0], ec, ev); end
      or32 = 1'b1; @(posedge clk); #1; or32 = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_backpressure();
    test_busy_ignore();
    test_reset_mid_busy();
    test_rand_w8();
    test_rand_w32();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end

endmodule
`default_nettype wire
